// File: rtl/vend_alu_sequencer.sv
// vend_alu_sequencer: holds vending credit and runs INSERT/BUY/REFUND through an external combinational ALU
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_type/cmd_data command channel;
// rsp_valid/rsp_ready/rsp_status/rsp_data response channel; vend_pulse strobe on a successful buy;
// credit/credit_zero status; alu_a/alu_b/alu_op drive the ALU, alu_result/alu_carry/alu_zero return from it.
module vend_alu_sequencer #(
  parameter int W = 5,
  parameter int ALU_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_type,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_status,
  output logic [W-1:0] rsp_data,
  output logic         vend_pulse,
  output logic [W-1:0] credit,
  output logic         credit_zero,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero
);
  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2;
  localparam logic [1:0] C_INS = 2'd0, C_BUY = 2'd1, C_REF = 2'd2, C_RSV = 2'd3;
  localparam logic [1:0] S_OK = 2'd0, S_OVF = 2'd1, S_INSUF = 2'd2, S_ILL = 2'd3;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    type_q, type_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  credit_q, credit_d;
  logic          cz_q, cz_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    status_q, status_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          vend_q, vend_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    data_d      = data_q;
    credit_d    = credit_q;
    cz_d        = cz_q;
    rsp_valid_d = rsp_valid_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    vend_d      = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = DRIVE;
        cnt_d   = '0;
        type_d  = cmd_type;
        data_d  = cmd_data;
        a_d     = credit_q;
        b_d     = (cmd_type == C_REF) ? credit_q : (cmd_type == C_RSV) ? '0 : cmd_data;
        op_d    = (cmd_type == C_BUY || cmd_type == C_REF) ? OP_SUB : OP_ADD;
      end
      DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ALU_WAIT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = credit_q;
          status_d    = S_OK;
          case (type_q)
            C_INS: if (alu_carry) status_d = S_OVF;
            else begin
              credit_d = alu_result;
              cz_d     = alu_zero;
              rdata_d  = alu_result;
            end
            // Affordability comes from a local compare; the ALU borrow is not trusted here.
            C_BUY: if (data_q > credit_q) status_d = S_INSUF;
            else begin
              credit_d = alu_result;
              cz_d     = alu_zero;
              rdata_d  = alu_result;
              vend_d   = 1'b1;
            end
            C_REF: begin
              credit_d = alu_result;
              cz_d     = alu_zero;
            end
            default: status_d = S_ILL;
          endcase
        end
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      data_q      <= '0;
      credit_q    <= '0;
      cz_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      status_q    <= S_OK;
      rdata_q     <= '0;
      vend_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      data_q      <= data_d;
      credit_q    <= credit_d;
      cz_q        <= cz_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      vend_q      <= vend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
    end
  end
  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = status_q;
  assign rsp_data    = rdata_q;
  assign vend_pulse  = vend_q;
  assign credit      = credit_q;
  assign credit_zero = cz_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
endmodule

// File: tb/tb_vend_alu_sequencer.sv
// tb_vend_alu_sequencer: table, directed and random checks of vend_alu_sequencer against a credit model
module tb_vend_alu_sequencer;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic         cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, vend_pulse, credit_zero;
  logic [1:0]   cmd_type = 0, rsp_status;
  logic [W-1:0] cmd_data = 0, rsp_data, credit, alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_carry, alu_zero;
  logic         c3_valid = 0, c3_ready, c3_rsp_valid, c3_rsp_ready = 0, c3_vend, c3_cz;
  logic [1:0]   c3_type = 0, c3_status;
  logic [W-1:0] c3_cdata = 0, c3_data, c3_credit, c3_a, c3_b, c3_res;
  logic [2:0]   c3_op;
  logic         c3_carry, c3_zero;
  int checks = 0, failures = 0, mcredit = 0;

  function automatic logic [W+1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [W:0] s;
    s = (op == 3'd1) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    return {s[W-1:0] == '0, s[W], s[W-1:0]};
  endfunction
  assign {alu_zero, alu_carry, alu_result} = alu(alu_a, alu_b, alu_op);
  assign {c3_zero, c3_carry, c3_res} = alu(c3_a, c3_b, c3_op);

  vend_alu_sequencer #(.W(W), .ALU_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_data(rsp_data), .vend_pulse(vend_pulse), .credit(credit), .credit_zero(credit_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero));

  vend_alu_sequencer #(.W(W), .ALU_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_type(c3_type),
    .cmd_data(c3_cdata), .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_status(c3_status),
    .rsp_data(c3_data), .vend_pulse(c3_vend), .credit(c3_credit), .credit_zero(c3_cz),
    .alu_a(c3_a), .alu_b(c3_b), .alu_op(c3_op), .alu_result(c3_res), .alu_carry(c3_carry),
    .alu_zero(c3_zero));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Credit model straight from the command rules: saturation-free, reject on overflow/underflow.
  task automatic model(input logic [1:0] t, input int d, output logic [1:0] st, output int rd, output int vp);
    vp = 0;
    st = 2'd0;
    case (t)
      2'd0: if (mcredit + d > 31) st = 2'd1; else mcredit += d;
      2'd1: if (d > mcredit) st = 2'd2; else begin mcredit -= d; vp = 1; end
      2'd2: ;
      default: st = 2'd3;
    endcase
    rd = (t == 2'd2) ? mcredit : mcredit;
    if (t == 2'd2) mcredit = 0;
  endtask

  task automatic run_cmd(input logic [1:0] t, input int d, input logic [1:0] est, input int erd,
                         input int evp, input int ecr, input int pc, input int dly);
    int vc, lat;
    logic [1:0] s;
    logic [W-1:0] r;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_type = t; cmd_data = W'(d);
    @(posedge clk); #1;
    cmd_valid = 0;
    vc = vend_pulse;
    chk("alu_a", alu_a, pc);
    chk("alu_b", alu_b, (t == 2'd2) ? pc : (t == 2'd3) ? 0 : d);
    chk("alu_op", alu_op, (t == 2'd1 || t == 2'd2) ? 1 : 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      vc += vend_pulse;
    end
    chk("latency", lat, 1);
    s = rsp_status;
    r = rsp_data;
    chk("rsp_status", s, est);
    chk("rsp_data", r, erd);
    chk("credit", credit, ecr);
    chk("credit_zero", credit_zero, ecr == 0);
    repeat (dly) begin
      @(posedge clk); #1;
      vc += vend_pulse;
      chk("rsp_hold", {rsp_valid, rsp_status, rsp_data}, {1'b1, s, r});
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    vc += vend_pulse;
    chk("rsp_drop", rsp_valid, 0);
    chk("vend_count", vc, evp);
  endtask

  typedef struct {
    logic [1:0] t;
    int d;
    logic [1:0] st;
    int rd;
    int vp;
    int cr;
  } vec_t;
  vec_t vec[18];

  initial begin
    logic [1:0] st, t;
    int rd, vp, pc, d, lat;
    vec[0]  = '{2'd0, 5, 2'd0, 5, 0, 5};
    vec[1]  = '{2'd0, 3, 2'd0, 8, 0, 8};
    vec[2]  = '{2'd1, 8, 2'd0, 0, 1, 0};
    vec[3]  = '{2'd0, 28, 2'd0, 28, 0, 28};
    vec[4]  = '{2'd0, 5, 2'd1, 28, 0, 28};
    vec[5]  = '{2'd0, 3, 2'd0, 31, 0, 31};
    vec[6]  = '{2'd2, 0, 2'd0, 31, 0, 0};
    vec[7]  = '{2'd0, 5, 2'd0, 5, 0, 5};
    vec[8]  = '{2'd1, 7, 2'd2, 5, 0, 5};
    vec[9]  = '{2'd2, 0, 2'd0, 5, 0, 0};
    vec[10] = '{2'd2, 0, 2'd0, 0, 0, 0};
    vec[11] = '{2'd1, 0, 2'd0, 0, 1, 0};
    vec[12] = '{2'd0, 9, 2'd0, 9, 0, 9};
    vec[13] = '{2'd3, 3, 2'd3, 9, 0, 9};
    vec[14] = '{2'd1, 9, 2'd0, 0, 1, 0};
    vec[15] = '{2'd0, 31, 2'd0, 31, 0, 31};
    vec[16] = '{2'd0, 1, 2'd1, 31, 0, 31};
    vec[17] = '{2'd1, 31, 2'd0, 0, 1, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_credit_zero", credit_zero, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_vend", vend_pulse, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 18; i++) begin
      pc = mcredit;
      model(vec[i].t, vec[i].d, st, rd, vp);
      run_cmd(vec[i].t, vec[i].d, vec[i].st, vec[i].rd, vec[i].vp, vec[i].cr, pc, 0);
    end

    // Backpressured response with a second command waiting behind it.
    cmd_valid = 1; cmd_type = 2'd0; cmd_data = 5'd2;
    @(posedge clk); #1;
    cmd_data = 5'd1;
    @(posedge clk); #1;
    chk("hold_rsp_valid", rsp_valid, 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, 2'd0, 5'd2});
      chk("hold_credit", credit, 2);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
    chk("hs_credit", credit, 2);
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("second_accept", cmd_ready, 0);
    @(posedge clk); #1;
    chk("second_rsp_valid", rsp_valid, 1);
    chk("second_rsp_data", rsp_data, 3);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    mcredit = 3;

    // Async reset in the middle of an operation.
    pc = mcredit;
    model(2'd0, 9, st, rd, vp);
    run_cmd(2'd0, 9, st, rd, vp, mcredit, pc, 0);
    cmd_valid = 1; cmd_type = 2'd0; cmd_data = 5'd3;
    @(posedge clk); #1;
    cmd_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_cz", credit_zero, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_op}, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_credit", credit, 0);
    mcredit = 0;

    // Longer ALU settle time: response lands ALU_WAIT edges after accept.
    for (int k = 0; k < 2; k++) begin
      c3_valid = 1; c3_type = k[1:0]; c3_cdata = 5'd4;
      @(posedge clk); #1;
      c3_valid = 0;
      lat = 0;
      while (!c3_rsp_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w3_latency", lat, 3);
      chk("w3_status", c3_status, 0);
      chk("w3_data", c3_data, (k == 0) ? 4 : 0);
      chk("w3_cz", c3_cz, k);
      c3_rsp_ready = 1;
      @(posedge clk); #1;
      c3_rsp_ready = 0;
    end

    for (int i = 0; i < 150; i++) begin
      t = 2'($urandom_range(0, 3));
      d = (t == 2'd0) ? $urandom_range(0, 12) : $urandom_range(0, 31);
      pc = mcredit;
      model(t, d, st, rd, vp);
      run_cmd(t, d, st, rd, vp, mcredit, pc, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
